regfile_bist: RTL and testbench
===============================

REGFILE_BIST -- requirements
Module: regfile_bist

Interface
REQ-001 Parameter PATTERN, default 64'h0000010204080001, per-register multiplier; expected value of Xi = i * PATTERN (64-bit truncated), X31 always 0.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  begin test; sampled only in IDLE or DONE.
REQ-005 busy  output  1  high in WRITE and READ states.
REQ-006 done  output  1  high in DONE state; holds until next accepted start or reset.
REQ-007 pass  output  1  valid while done; 1 = all 32 registers matched.
REQ-008 fail_reg  output  5  valid while done and pass=0; index of first mismatching register.
REQ-009 writeData  output  64  regfile write data.
REQ-010 writeReg  output  5  regfile write index.
REQ-011 regWrEn  output  1  regfile write enable; regfile captures on rising clk.
REQ-012 readReg0 / readReg1  output  5 each  regfile read indices.
REQ-013 readData0 / readData1  input  64 each  regfile read data, combinational from readReg0/readReg1.

Function
REQ-014 States: IDLE, WRITE, READ, DONE; 5-bit index counter idx.
REQ-015 IDLE/DONE with start=1 -> WRITE, idx=0, done/pass/fail_reg cleared; start ignored in WRITE/READ.
REQ-016 WRITE: regWrEn=1, writeReg=idx, writeData=idx*PATTERN for every idx including 31 (X31 write attempt with nonzero data when PATTERN*31 != 0).
REQ-017 WRITE lasts exactly 32 cycles; idx 31 -> READ with idx wrapping to 0.
REQ-018 READ: regWrEn=0, readReg0=idx, readReg1=31-idx; compare readData0 against expected(idx) and readData1 against expected(31-idx) in the same cycle.
REQ-019 Expected value for index 31 is 64'h0 regardless of PATTERN.
REQ-020 On first mismatch: -> DONE next cycle, pass=0, fail_reg=idx if port 0 mismatched, else 31-idx (port 0 has priority on simultaneous mismatch).
REQ-021 READ with no mismatch at idx 31 -> DONE, pass=1, fail_reg=0.
REQ-022 Latency: start accepted at edge N -> done high after edge N+64 on full pass; earlier on failure.
REQ-023 Outside WRITE, regWrEn=0; outside WRITE/READ, writeReg/readReg0/readReg1=0 and writeData=0.
REQ-024 Multiplication width: 5-bit idx zero-extended to 64 bits, product truncated to 64 bits.

Reset
REQ-025 reset_n low forces IDLE, idx=0, busy=0, done=0, pass=0, fail_reg=0, regWrEn=0, all address/data outputs 0, immediately and asynchronously.
REQ-026 Reset mid-WRITE or mid-READ aborts the test; no further regfile writes until a new start after reset_n deasserts.

Structure
REQ-027 Shared package regfile_pkg holds NUM_REGS=32, ZERO_REG=5'd31, REG_W=64, and the bist state enum.
REQ-028 One sub-module regfile_bist_check: combinational dual-port expected-value generator and comparator returning mismatch0, mismatch1.

Verification
REQ-029 Good regfile, start pulse -> 32 writes X0..X31, 32 read cycles, done=1 and pass=1 exactly 64 cycles after start edge.
REQ-030 Regfile model with bit 0 of X5 stuck at 0 -> done, pass=0, fail_reg=5 (detected on port 0 at idx=5).
REQ-031 Regfile model where X31 is writable -> pass=0, fail_reg=31 (port 1 mismatch at idx=0).
REQ-032 reset_n pulsed low at WRITE idx=10 -> all outputs 0 during reset, IDLE after; subsequent start yields pass=1.
REQ-033 start held high through WRITE/READ -> no restart; after done, start re-accepted, done cleared next cycle.
REQ-034 PATTERN=64'hFFFF_FFFF_FFFF_FFFF override -> writeData for idx=3 equals 64'hFFFF_FFFF_FFFF_FFFD, pass=1 on good regfile.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file self-test.
// The helper functions produce each register's write value and its expected read value.
package regfile_pkg;
  localparam int         NUM_REGS = 32;
  localparam logic [4:0] ZERO_REG = 5'd31;
  localparam int         REG_W    = 64;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} bistState_t;

  function automatic logic [REG_W-1:0] idxMul(input logic [4:0] idx, input logic [REG_W-1:0] pat);
    return {{(REG_W-5){1'b0}}, idx} * pat;
  endfunction

  // X31 is hardwired to zero, so its expected read value ignores the pattern
  function automatic logic [REG_W-1:0] expVal(input logic [4:0] idx, input logic [REG_W-1:0] pat);
    return (idx == ZERO_REG) ? '0 : idxMul(idx, pat);
  endfunction
endpackage

// File: rtl/regfile_bist_check.sv
// Dual-port comparator: checks both read ports against their expected values
// in the same cycle.
module regfile_bist_check
  import regfile_pkg::*;
#(
  parameter logic [REG_W-1:0] PATTERN = 64'h0000010204080001
) (
  input  logic [4:0]       idx0,
  input  logic [4:0]       idx1,
  input  logic [REG_W-1:0] readData0,
  input  logic [REG_W-1:0] readData1,
  output logic             mismatch0,
  output logic             mismatch1
);
  assign mismatch0 = (readData0 != expVal(idx0, PATTERN));
  assign mismatch1 = (readData1 != expVal(idx1, PATTERN));
endmodule

// File: rtl/regfile_bist.sv
// Register-file BIST: writes i*PATTERN into every register, then reads the
// registers back in pairs (i, 31-i) and reports the first register that mismatches.
module regfile_bist
  import regfile_pkg::*;
#(
  parameter logic [REG_W-1:0] PATTERN = 64'h0000010204080001
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [4:0]       fail_reg,
  output logic [REG_W-1:0] writeData,
  output logic [4:0]       writeReg,
  output logic             regWrEn,
  output logic [4:0]       readReg0,
  output logic [4:0]       readReg1,
  input  logic [REG_W-1:0] readData0,
  input  logic [REG_W-1:0] readData1
);
  bistState_t state, stateNxt;
  logic [4:0] idx, idxNxt;
  logic       passQ, passNxt;
  logic [4:0] failQ, failNxt;
  logic       mismatch0, mismatch1;

  regfile_bist_check #(.PATTERN(PATTERN)) uCheck (
    .idx0      (readReg0),
    .idx1      (readReg1),
    .readData0 (readData0),
    .readData1 (readData1),
    .mismatch0 (mismatch0),
    .mismatch1 (mismatch1)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      passQ <= 1'b0;
      failQ <= '0;
    end else begin
      state <= stateNxt;
      idx   <= idxNxt;
      passQ <= passNxt;
      failQ <= failNxt;
    end
  end

  always_comb begin
    stateNxt  = state;
    idxNxt    = idx;
    passNxt   = passQ;
    failNxt   = failQ;
    busy      = 1'b0;
    done      = 1'b0;
    regWrEn   = 1'b0;
    writeReg  = '0;
    writeData = '0;
    readReg0  = '0;
    readReg1  = '0;
    unique case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          stateNxt = WRITE;
          idxNxt   = '0;
          passNxt  = 1'b0;
          failNxt  = '0;
        end
      end
      WRITE: begin
        busy      = 1'b1;
        regWrEn   = 1'b1;
        writeReg  = idx;
        // X31 is written too, so a register that fails to stay at zero is caught
        writeData = idxMul(idx, PATTERN);
        idxNxt    = idx + 5'd1;
        if (idx == ZERO_REG) stateNxt = READ;
      end
      READ: begin
        busy     = 1'b1;
        readReg0 = idx;
        readReg1 = ZERO_REG - idx;
        idxNxt   = idx + 5'd1;
        if (mismatch0) begin
          stateNxt = DONE;
          passNxt  = 1'b0;
          failNxt  = idx;
        end else if (mismatch1) begin
          stateNxt = DONE;
          passNxt  = 1'b0;
          failNxt  = ZERO_REG - idx;
        end else if (idx == ZERO_REG) begin
          stateNxt = DONE;
          passNxt  = 1'b1;
          failNxt  = '0;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  assign pass     = passQ;
  assign fail_reg = failQ;
endmodule

// File: tb/tb_regfile_bist.sv
// Directed bench: a behavioural register file with injectable faults drives
// the default-pattern DUT; a second DUT exercises an all-ones pattern.
module tb_regfile_bist;
  logic        clk, reset_n;
  logic        startA, startB;
  logic        busyA, doneA, passA, weA;
  logic [4:0]  failA, wrA, rr0A, rr1A;
  logic [63:0] wdA, rd0A, rd1A;
  logic        busyB, doneB, passB, weB;
  logic [4:0]  failB, wrB, rr0B, rr1B;
  logic [63:0] wdB, rd0B, rd1B;

  logic [63:0] rfA [32];
  logic [63:0] rfB [32];
  logic        stuck5, x31Wr;
  int          total, bad, wrCnt;

  regfile_bist dutA (
    .clk(clk), .reset_n(reset_n), .start(startA), .busy(busyA), .done(doneA),
    .pass(passA), .fail_reg(failA), .writeData(wdA), .writeReg(wrA), .regWrEn(weA),
    .readReg0(rr0A), .readReg1(rr1A), .readData0(rd0A), .readData1(rd1A)
  );

  regfile_bist #(.PATTERN(64'hFFFF_FFFF_FFFF_FFFF)) dutB (
    .clk(clk), .reset_n(reset_n), .start(startB), .busy(busyB), .done(doneB),
    .pass(passB), .fail_reg(failB), .writeData(wdB), .writeReg(wrB), .regWrEn(weB),
    .readReg0(rr0B), .readReg1(rr1B), .readData0(rd0B), .readData1(rd1B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (weA) begin rfA[wrA] <= wdA; wrCnt <= wrCnt + 1; end
    if (weB) rfB[wrB] <= wdB;
  end

  always_comb begin
    rd0A = rfA[rr0A];
    if (rr0A == 5'd31 && !x31Wr) rd0A = '0;
    if (stuck5 && rr0A == 5'd5) rd0A[0] = 1'b0;
    rd1A = rfA[rr1A];
    if (rr1A == 5'd31 && !x31Wr) rd1A = '0;
    if (stuck5 && rr1A == 5'd5) rd1A[0] = 1'b0;
  end

  always_comb begin
    rd0B = (rr0B == 5'd31) ? 64'h0 : rfB[rr0B];
    rd1B = (rr1B == 5'd31) ? 64'h0 : rfB[rr1B];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pulseA();
    @(negedge clk); startA = 1'b1;
    @(negedge clk); startA = 1'b0;
  endtask

  // returns the number of negedges until done rises, capped at budget
  task automatic waitDoneA(input int budget, output int n);
    n = 0;
    while (!doneA && n < budget) begin @(negedge clk); n++; end
  endtask

  task automatic chkIdleOutsA(input string tag);
    chk({tag, "_busy"}, busyA, 0);
    chk({tag, "_done"}, doneA, 0);
    chk({tag, "_pass"}, passA, 0);
    chk({tag, "_fail"}, failA, 0);
    chk({tag, "_we"}, weA, 0);
    chk({tag, "_wd"}, wdA, 0);
    chk({tag, "_wr"}, wrA, 0);
    chk({tag, "_rr0"}, rr0A, 0);
    chk({tag, "_rr1"}, rr1A, 0);
  endtask

  initial begin
    int n, wsave;
    total = 0; bad = 0; wrCnt = 0;
    stuck5 = 1'b0; x31Wr = 1'b0;
    startA = 1'b0; startB = 1'b0;
    for (int i = 0; i < 32; i++) begin rfA[i] = '0; rfB[i] = '0; end
    reset_n = 1'b0;
    #12;
    chkIdleOutsA("rst");
    @(negedge clk); reset_n = 1'b1;

    // good regfile, exact latency
    pulseA();
    chk("w0_we", weA, 1); chk("w0_busy", busyA, 1);
    chk("w0_wr", wrA, 0); chk("w0_wd", wdA, 64'h0);
    @(negedge clk);
    chk("w1_wd", wdA, 64'h0000010204080001);
    @(negedge clk);
    chk("w2_wr", wrA, 2); chk("w2_wd", wdA, 64'h0000020408100002);
    repeat (29) @(negedge clk);
    chk("w31_wr", wrA, 31); chk("w31_wd", wdA, 64'h00001F3E7CF8001F);
    @(negedge clk);
    chk("r0_we", weA, 0); chk("r0_rr0", rr0A, 0); chk("r0_rr1", rr1A, 31);
    repeat (31) @(negedge clk);
    chk("k63_done", doneA, 0);
    @(negedge clk);
    chk("k64_done", doneA, 1); chk("k64_pass", passA, 1);
    chk("k64_busy", busyA, 0); chk("k64_fail", failA, 0);

    // bit 0 of X5 stuck low: port 0 at idx 5
    stuck5 = 1'b1;
    pulseA(); waitDoneA(80, n);
    chk("stuck_lat", n, 38); chk("stuck_pass", passA, 0); chk("stuck_fail", failA, 5);
    stuck5 = 1'b0;

    // X31 writable: port 1 at idx 0
    x31Wr = 1'b1;
    pulseA(); waitDoneA(80, n);
    chk("x31_lat", n, 33); chk("x31_pass", passA, 0); chk("x31_fail", failA, 31);
    x31Wr = 1'b0;

    // reset in the middle of WRITE
    pulseA();
    repeat (10) @(negedge clk);
    chk("mid_wr", wrA, 10);
    reset_n = 1'b0; #1;
    chkIdleOutsA("midrst");
    wsave = wrCnt;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", busyA, 0); chk("post_rst_done", doneA, 0);
    chk("post_rst_wr", wrCnt, wsave);
    pulseA(); waitDoneA(80, n);
    chk("rerun_lat", n, 64); chk("rerun_pass", passA, 1);

    // start held high: no restart mid-test, re-accepted from DONE
    @(negedge clk); startA = 1'b1;
    @(negedge clk);
    repeat (63) @(negedge clk);
    chk("hold_k63_done", doneA, 0);
    @(negedge clk);
    chk("hold_k64_done", doneA, 1); chk("hold_k64_pass", passA, 1);
    @(negedge clk);
    chk("hold_k65_done", doneA, 0); chk("hold_k65_busy", busyA, 1);
    chk("hold_k65_pass", passA, 0);
    startA = 1'b0;
    waitDoneA(80, n);
    chk("hold_lat", n, 64); chk("hold_pass", passA, 1);

    // all-ones pattern
    @(negedge clk); startB = 1'b1;
    @(negedge clk); startB = 1'b0;
    repeat (3) @(negedge clk);
    chk("ones_wr3", wrB, 3); chk("ones_wd3", wdB, 64'hFFFF_FFFF_FFFF_FFFD);
    n = 3;
    while (!doneB && n < 80) begin @(negedge clk); n++; end
    chk("ones_lat", n, 64); chk("ones_pass", passB, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
